// File: rtl/decode_stage.sv
// Purpose : RISC-V instruction decode (opcode/funct/register fields, sign-extended immediate,
//           legal/illegal class) feeding a 2-entry in-order output buffer, plus wrap-around stats.
// Latency : 1 cycle from accept edge to out_valid; nothing is combinational from inputs to outputs.
// Backpressure: in_ready is registered and high while fewer than 2 records are buffered.
//           out_ready only pops the head. The head holds stable while stalled.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/instruction from fetch;
//           out_valid/out_ready plus op, funct3, funct7, rs1, rs2, rd, imm, fmt, illegal to execute;
//           decoded_count/illegal_count statistics.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } rec_t;

  rec_t             head_q, head_d;    // record presented on the outputs
  rec_t             spill_q, spill_d;  // second entry, only meaningful when cnt_q == 2
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  rec_t        dec;
  logic [2:0]  fmt_c;
  logic [31:0] imm32;
  logic        push;
  logic        pop;

  // Format classification and field/immediate assembly.
  always_comb begin
    fmt_c = FMT_ILL;
    imm32 = '0;
    dec   = '0;
    dec.op = instruction[6:0];

    if (instruction[1:0] == 2'b11) begin
      case (instruction[6:0])
        7'b0110011, 7'b1010011:                       fmt_c = FMT_R;
        7'b1101111:                                   fmt_c = FMT_J;
        7'b0010111, 7'b0110111:                       fmt_c = FMT_U;
        7'b0100011, 7'b0100111:                       fmt_c = FMT_S;
        7'b1100011:                                   fmt_c = FMT_B;
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111: fmt_c = FMT_I;
        7'b0111011: if (XLEN == 64) fmt_c = FMT_R;   // RV64 OP-32
        7'b0011011: if (XLEN == 64) fmt_c = FMT_I;   // RV64 OP-IMM-32
        default:                                      fmt_c = FMT_ILL;
      endcase
    end

    case (fmt_c)
      FMT_R: begin
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.rd     = instruction[11:7];
        dec.funct3 = instruction[14:12];
        dec.funct7 = instruction[31:25];
      end
      FMT_I: begin
        dec.rs1    = instruction[19:15];
        dec.rd     = instruction[11:7];
        dec.funct3 = instruction[14:12];
        imm32      = {{20{instruction[31]}}, instruction[31:20]};
      end
      FMT_S: begin
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.funct3 = instruction[14:12];
        imm32      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      FMT_B: begin
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.funct3 = instruction[14:12];
        imm32      = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                      instruction[11:8], 1'b0};
      end
      FMT_U: begin
        dec.rd = instruction[11:7];
        imm32  = {instruction[31:12], 12'b0};
      end
      FMT_J: begin
        dec.rd = instruction[11:7];
        imm32  = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase

    dec.fmt = fmt_c;
    // Every immediate is already sign-extended to 32 bits; widen from bit 31 for RV64.
    dec.imm = XLEN'($signed(imm32));
  end

  assign push      = in_valid && in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Buffer next state. in_ready is low at occupancy 2, so push and pop never both
  // hit a full buffer; at occupancy 1 a simultaneous push replaces the head.
  always_comb begin
    head_d    = head_q;
    spill_d   = spill_q;
    cnt_d     = cnt_q;
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;

    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = dec;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = dec;
        end else if (push) begin
          spill_d = dec;
          cnt_d   = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = spill_q;
          cnt_d  = 2'd1;
        end
      end
    endcase

    if (push) begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
      if (dec.illegal) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end

    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      spill_q    <= '0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
      dec_cnt_q  <= '0;
      ill_cnt_q  <= '0;
    end else begin
      head_q     <= head_d;
      spill_q    <= spill_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      dec_cnt_q  <= dec_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign op            = head_q.op;
  assign funct3        = head_q.funct3;
  assign funct7        = head_q.funct7;
  assign rs1           = head_q.rs1;
  assign rs2           = head_q.rs2;
  assign rd            = head_q.rd;
  assign imm           = head_q.imm;
  assign fmt           = head_q.fmt;
  assign illegal       = head_q.illegal;
  assign decoded_count = dec_cnt_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 instance (CNT_W=16) and an RV64 instance (CNT_W=4) share
// one stimulus stream; expected records are queued on accept and popped by per-instance monitors.
// Shared flow control keeps both instances' occupancy identical.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [6:0]  a_op, a_funct7;
  logic [2:0]  a_funct3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_imm;
  logic [15:0] a_dec_cnt, a_ill_cnt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [6:0]  b_op, b_funct7;
  logic [2:0]  b_funct3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_imm;
  logic [3:0]  b_dec_cnt, b_ill_cnt;

  decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instruction(instruction), .out_valid(a_out_valid), .out_ready(out_ready),
    .op(a_op), .funct3(a_funct3), .funct7(a_funct7), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal),
    .decoded_count(a_dec_cnt), .illegal_count(a_ill_cnt)
  );

  decode_stage #(.XLEN(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instruction(instruction), .out_valid(b_out_valid), .out_ready(out_ready),
    .op(b_op), .funct3(b_funct3), .funct7(b_funct7), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal),
    .decoded_count(b_dec_cnt), .illegal_count(b_ill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;    // RV64 value; RV32 expects the low 32 bits
    logic [2:0]  fmt32, fmt64;
  } vec_t;

  vec_t vec[10];
  int   qa[$];
  int   qb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_acc   = 0;
  int   n_ill32 = 0;
  int   n_ill64 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [6:0] o, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [63:0] im,
                              input logic [2:0] t32, input logic [2:0] t64);
    vec_t v;
    v.instr = w; v.op = o; v.f3 = f3; v.f7 = f7; v.rs1 = s1; v.rs2 = s2; v.rd = d;
    v.imm = im; v.fmt32 = t32; v.fmt64 = t64;
    return v;
  endfunction

  // Monitors: sampled on the falling edge, a head with out_ready high is consumed at the next rise.
  always @(negedge clk) begin
    if (!rst && a_out_valid && out_ready) begin
      if (qa.size() == 0) check("a_spurious_output", 1, 0);
      else begin
        int i;
        i = qa.pop_front();
        check("a_fields", {a_op, a_funct3, a_funct7, a_rs1, a_rs2, a_rd},
              {vec[i].op, vec[i].f3, vec[i].f7, vec[i].rs1, vec[i].rs2, vec[i].rd});
        check("a_imm", a_imm, vec[i].imm[31:0]);
        check("a_fmt", a_fmt, vec[i].fmt32);
        check("a_illegal", a_illegal, vec[i].fmt32 == 3'd7);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && out_ready) begin
      if (qb.size() == 0) check("b_spurious_output", 1, 0);
      else begin
        int i;
        i = qb.pop_front();
        check("b_fields", {b_op, b_funct3, b_funct7, b_rs1, b_rs2, b_rd},
              {vec[i].op, vec[i].f3, vec[i].f7, vec[i].rs1, vec[i].rs2, vec[i].rd});
        check("b_imm", b_imm, vec[i].imm);
        check("b_fmt", b_fmt, vec[i].fmt64);
        check("b_illegal", b_illegal, vec[i].fmt64 == 3'd7);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge. in_valid stays high.
  task automatic send(input int idx);
    int w = 0;
    in_valid    = 1'b1;
    instruction = vec[idx].instr;
    @(negedge clk);
    while (!a_in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!a_in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      qa.push_back(idx);
      qb.push_back(idx);
      n_acc++;
      if (vec[idx].fmt32 == 3'd7) n_ill32++;
      if (vec[idx].fmt64 == 3'd7) n_ill64++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", qa.size() + qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("a_decoded_count", a_dec_cnt, n_acc[15:0]);
    check("a_illegal_count", a_ill_cnt, n_ill32[15:0]);
    check("b_decoded_count", b_dec_cnt, n_acc[3:0]);
    check("b_illegal_count", b_ill_cnt, n_ill64[3:0]);
  endtask

  initial begin
    vec[0] = mk(32'hFFF10093, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1); // addi x1,x2,-1
    vec[1] = mk(32'hFFDFF0EF, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'hFFFFFFFFFFFFFFFC, 3'd5, 3'd5); // jal x1,-4
    vec[2] = mk(32'h123452B7, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 64'h0000000012345000, 3'd4, 3'd4); // lui x5
    vec[3] = mk(32'h0020A423, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 64'h0000000000000008, 3'd2, 3'd2); // sw x2,8(x1)
    vec[4] = mk(32'hFE000CE3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3); // beq -8
    vec[5] = mk(32'h00000000, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0,                3'd7, 3'd7); // all zero
    vec[6] = mk(32'h0000003B, 7'h3B, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0,                3'd7, 3'd0); // OP-32
    vec[7] = mk(32'h402081B3, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 64'h0,                3'd0, 3'd0); // sub x3,x1,x2
    vec[8] = mk(32'hFFF10090, 7'h10, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0,                3'd7, 3'd7); // low bits 00
    vec[9] = mk(32'h7FF2A203, 7'h03, 3'd2, 7'h00, 5'd5, 5'd0, 5'd4, 64'h00000000000007FF, 3'd1, 3'd1); // lw x4,2047(x5)

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_fmt_imm", {a_fmt, a_imm}, 0);
    check("rst_b_state", {b_out_valid, b_in_ready, b_op, b_imm}, {1'b0, 1'b1, 7'h0, 64'h0});
    check_counts();
    @(posedge clk); #1;

    // Streaming with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(i);
    drain();
    check_counts();

    // One-cycle latency: idle before, valid right after the accepting edge
    @(negedge clk);
    check("idle_out_valid", a_out_valid, 0);
    @(posedge clk); #1;
    send(0);
    check("latency_out_valid", a_out_valid, 1);
    drain();

    // Backpressure: two accepts fill the buffer, third waits for the first pop
    out_ready = 1'b0;
    send(1);
    send(2);
    instruction = vec[3].instr;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_in_ready", a_in_ready, 0);
      check("stall_head", {a_out_valid, a_op, a_rd, a_imm}, {1'b1, vec[1].op, vec[1].rd, vec[1].imm[31:0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3);
    drain();
    check_counts();

    // Reset with two records buffered
    out_ready = 1'b0;
    send(4);
    send(7);
    in_valid = 1'b0;
    rst = 1'b1;
    qa.delete(); qb.delete();
    n_acc = 0; n_ill32 = 0; n_ill64 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", {a_out_valid, a_in_ready, a_op, a_fmt}, {1'b1 ^ 1'b1, 1'b1, 7'h0, 3'h0});
    check_counts();
    @(posedge clk); #1;

    // 16 accepts wrap the 4-bit counter to zero
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(0);
    drain();
    check("b_wrap_count", b_dec_cnt, 4'd0);
    check("a_no_wrap_count", a_dec_cnt, 16'd16);
    check_counts();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
